rob_commit: RTL and testbench

In-order retirement stage directly downstream of the ROB FIFO. It mirrors the FIFO's head/tail pointers and keeps a per-entry completion table written by the CDB. When the head entry has completed, it pops the FIFO, merges the popped static fields with the stored result, and drives the architectural register-file write port. On a mispredicted branch reaching head, it commits that branch and pulses a pipeline flush.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_status_table.sv | 72 +++++++
 rtl/rob_commit.sv | 104 ++++++++++
 tb/tb_rob_commit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the ROB retirement stage.
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int XLEN      = 32;
  localparam int TAG_W     = $clog2(ROB_DEPTH);

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WB   = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic            valid;
    rob_tag_t        tag;
    logic [XLEN-1:0] value;
    logic            mispredict;
    logic [XLEN-1:0] target;
  } cdb_pkt_t;
endpackage

// File: rtl/rob_status_table.sv
// Per-entry completion table: valid/done flags plus the result, mispredict and target from the CDB.
module rob_status_table
  import rob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_en,
  input  rob_tag_t        alloc_tag,
  input  cdb_pkt_t        cdb,
  input  logic            retire_en,
  input  rob_tag_t        head_tag,
  input  logic            flush_clr,
  output logic            head_done,
  output logic [XLEN-1:0] head_value,
  output logic            head_mispredict,
  output logic [XLEN-1:0] head_target
);
  logic [ROB_DEPTH-1:0] valid_vec;
  logic [ROB_DEPTH-1:0] done_vec;
  logic [ROB_DEPTH-1:0] misp_vec;
  logic [XLEN-1:0]      value_arr  [ROB_DEPTH];
  logic [XLEN-1:0]      target_arr [ROB_DEPTH];

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      logic            valid_reg;
      logic            done_reg;
      logic            misp_reg;
      logic [XLEN-1:0] value_reg;
      logic [XLEN-1:0] target_reg;
      logic            hit_alloc;
      logic            hit_cdb;
      logic            hit_retire;

      assign hit_alloc  = alloc_en && (alloc_tag == rob_tag_t'(gi));
      assign hit_retire = retire_en && (head_tag == rob_tag_t'(gi));
      // Completions for entries not currently in flight are stale and dropped.
      assign hit_cdb    = cdb.valid && (cdb.tag == rob_tag_t'(gi)) && valid_reg;

      always_ff @(posedge clk) begin
        if (rst || flush_clr) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (hit_alloc) begin
          valid_reg <= 1'b1;
          done_reg  <= 1'b0;
        end else if (hit_retire) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (hit_cdb) begin
          done_reg <= 1'b1;
        end
        if (hit_cdb && !flush_clr) begin
          value_reg  <= cdb.value;
          misp_reg   <= cdb.mispredict;
          target_reg <= cdb.target;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign done_vec[gi]   = done_reg;
      assign misp_vec[gi]   = misp_reg;
      assign value_arr[gi]  = value_reg;
      assign target_arr[gi] = target_reg;
    end
  endgenerate

  assign head_done       = done_vec[head_tag];
  assign head_value      = value_arr[head_tag];
  assign head_mispredict = misp_vec[head_tag];
  assign head_target     = target_arr[head_tag];
endmodule

// File: rtl/rob_commit.sv
// In-order retirement: mirrors ROB FIFO pointers, pops completed heads and drives the arch register write port.
module rob_commit
  import rob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_en,
  output logic            alloc_ready,
  output rob_tag_t        alloc_tag,
  input  logic            cdb_valid,
  input  rob_tag_t        cdb_tag,
  input  logic [XLEN-1:0] cdb_value,
  input  logic            cdb_mispredict,
  input  logic [XLEN-1:0] cdb_target,
  output logic            rob_rd_en,
  input  logic [4:0]      rob_head_areg,
  input  logic            rob_head_has_dest,
  input  logic [XLEN-1:0] rob_head_pc,
  output logic            commit_valid,
  output logic            commit_we,
  output logic [4:0]      commit_areg,
  output logic [XLEN-1:0] commit_value,
  output logic [XLEN-1:0] commit_pc,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc
);
  typedef logic [TAG_W:0] count_t;

  commit_state_e   state_reg, state_next;
  rob_tag_t        head_reg, tail_reg;
  count_t          count_reg, count_next;
  logic            in_wb;
  logic            alloc_fire;
  logic            head_done;
  logic            head_mispredict;
  logic [XLEN-1:0] head_value;
  logic [XLEN-1:0] head_target;
  cdb_pkt_t        cdb_pkt;

  assign cdb_pkt = '{valid: cdb_valid, tag: cdb_tag, value: cdb_value,
                     mispredict: cdb_mispredict, target: cdb_target};

  rob_status_table u_table (
    .clk             (clk),
    .rst             (rst),
    .alloc_en        (alloc_fire),
    .alloc_tag       (tail_reg),
    .cdb             (cdb_pkt),
    .retire_en       (in_wb),
    .head_tag        (head_reg),
    .flush_clr       (flush),
    .head_done       (head_done),
    .head_value      (head_value),
    .head_mispredict (head_mispredict),
    .head_target     (head_target)
  );

  // Gating with rst lets a reset landing in WB abort the retirement outright.
  assign in_wb       = (state_reg == WB) && !rst;
  assign flush       = in_wb && head_mispredict;
  assign alloc_ready = (count_reg < count_t'(ROB_DEPTH)) && !flush;
  assign alloc_tag   = tail_reg;
  assign alloc_fire  = alloc_en && alloc_ready;
  assign rob_rd_en   = !rst && (state_reg == IDLE) && (count_reg != '0) && head_done;

  assign commit_valid = in_wb;
  assign commit_we    = in_wb && rob_head_has_dest && (rob_head_areg != 5'd0);
  assign commit_areg  = in_wb ? rob_head_areg : 5'd0;
  assign commit_value = in_wb ? head_value : '0;
  assign commit_pc    = in_wb ? rob_head_pc : '0;
  assign flush_pc     = flush ? head_target : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rob_rd_en) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({alloc_fire, in_wb})
      2'b10:   count_next = count_reg + count_t'(1);
      2'b01:   count_next = count_reg - count_t'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg <= IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (in_wb)      head_reg <= head_reg + rob_tag_t'(1);
      if (alloc_fire) tail_reg <= tail_reg + rob_tag_t'(1);
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with a ROB FIFO model and a commit scoreboard.
module tb_rob_commit;
  import rob_pkg::*;

  typedef struct packed {
    logic [4:0]  areg;
    logic        hd;
    logic [31:0] pc;
  } fent_t;

  typedef struct packed {
    logic [4:0]  areg;
    logic        we;
    logic [31:0] value;
    logic [31:0] pc;
    logic        misp;
    logic [31:0] tgt;
  } exp_t;

  logic            clk, rst;
  logic            alloc_en, alloc_ready;
  rob_tag_t        alloc_tag;
  logic            cdb_valid;
  rob_tag_t        cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic            cdb_mispredict;
  logic [XLEN-1:0] cdb_target;
  logic            rob_rd_en;
  logic [4:0]      rob_head_areg;
  logic            rob_head_has_dest;
  logic [XLEN-1:0] rob_head_pc;
  logic            commit_valid, commit_we;
  logic [4:0]      commit_areg;
  logic [XLEN-1:0] commit_value, commit_pc;
  logic            flush;
  logic [XLEN-1:0] flush_pc;

  int vectors = 0;
  int miscompares = 0;

  exp_t        exp_q[$];
  fent_t       fifo_q[$];
  fent_t       hd_ent = '0;
  logic [4:0]  a_areg = '0;
  logic        a_hd = 1'b0;
  logic [31:0] a_pc = '0;
  logic [31:0] t_val [8];
  logic        t_misp [8];
  logic [31:0] t_tgt [8];
  logic        prev_rd = 1'b0;
  logic        f_push, f_pop, f_clr;

  rob_commit dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rob_rd_en(rob_rd_en), .rob_head_areg(rob_head_areg),
    .rob_head_has_dest(rob_head_has_dest), .rob_head_pc(rob_head_pc),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_areg(commit_areg),
    .commit_value(commit_value), .commit_pc(commit_pc),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ROB FIFO model: data_out shows the popped entry from the cycle after rd_en.
  always @(posedge clk) begin
    f_push = alloc_en && alloc_ready;
    f_pop  = rob_rd_en;
    f_clr  = rst || flush;
    if (f_clr) fifo_q.delete();
    else begin
      if (f_pop && fifo_q.size() > 0) hd_ent = fifo_q.pop_front();
      if (f_push) fifo_q.push_back('{a_areg, a_hd, a_pc});
    end
    #1;
    rob_head_areg     = hd_ent.areg;
    rob_head_has_dest = hd_ent.hd;
    rob_head_pc       = hd_ent.pc;
  end

  // Commit monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      prev_rd = 1'b0;
    end else begin
      chk("rd_to_commit", 32'(commit_valid), 32'(prev_rd));
      if (commit_valid) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("commit areg=%0d we=%0b value=%0h pc=%0h flush=%0b",
                   commit_areg, commit_we, commit_value, commit_pc, flush);
          chk("commit_areg", 32'(commit_areg), 32'(e.areg));
          chk("commit_we", 32'(commit_we), 32'(e.we));
          chk("commit_value", commit_value, e.value);
          chk("commit_pc", commit_pc, e.pc);
          chk("flush", 32'(flush), 32'(e.misp));
          if (e.misp) begin
            chk("flush_pc", flush_pc, e.tgt);
            exp_q.delete();
          end
        end
      end
      prev_rd = rob_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    alloc_en = 1'b0; cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    @(negedge clk);
    chk({p, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    chk({p, "_alloc_tag"}, 32'(alloc_tag), 32'd0);
    chk({p, "_rd_en"}, 32'(rob_rd_en), 32'd0);
    chk({p, "_commit_valid"}, 32'(commit_valid), 32'd0);
    chk({p, "_commit_we"}, 32'(commit_we), 32'd0);
    chk({p, "_commit_areg"}, 32'(commit_areg), 32'd0);
    chk({p, "_commit_value"}, commit_value, 32'd0);
    chk({p, "_commit_pc"}, commit_pc, 32'd0);
    chk({p, "_flush"}, 32'(flush), 32'd0);
    chk({p, "_flush_pc"}, flush_pc, 32'd0);
  endtask

  task automatic alloc(input logic [4:0] areg, input logic hd, input logic [31:0] pc,
                       input logic [31:0] val, input logic misp, input logic [31:0] tgt,
                       input int exp_tag);
    chk("alloc_ready", 32'(alloc_ready), 32'd1);
    chk("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    alloc_en = 1'b1; a_areg = areg; a_hd = hd; a_pc = pc;
    t_val[exp_tag] = val; t_misp[exp_tag] = misp; t_tgt[exp_tag] = tgt;
    exp_q.push_back('{areg, hd && (areg != 5'd0), val, pc, misp, tgt});
    tick();
  endtask

  task automatic drive_cdb(input int tag);
    cdb_valid = 1'b1; cdb_tag = rob_tag_t'(tag);
    cdb_value = t_val[tag]; cdb_mispredict = t_misp[tag]; cdb_target = t_tgt[tag];
  endtask

  task automatic complete(input int tag);
    drive_cdb(tag);
    tick();
  endtask

  task automatic wait_commit(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!commit_valid && cyc < 30);
    chk({name, "_seen"}, 32'(commit_valid), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    rst = 1'b1; alloc_en = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    cdb_mispredict = 1'b0; cdb_target = '0;
    rob_head_areg = '0; rob_head_has_dest = 1'b0; rob_head_pc = '0;
    for (int i = 0; i < 8; i++) begin t_val[i] = '0; t_misp[i] = 1'b0; t_tgt[i] = '0; end

    // Reset state, then basic retire latency
    do_reset();
    chk_reset_vals("reset");
    alloc(5'd5, 1'b1, 32'h100, 32'h11, 1'b0, 32'h0, 0);
    alloc(5'd6, 1'b1, 32'h104, 32'h22, 1'b0, 32'h0, 1);
    alloc(5'd7, 1'b1, 32'h108, 32'h33, 1'b0, 32'h0, 2);
    drive_cdb(0);
    @(negedge clk); chk("lat_rd_n", 32'(rob_rd_en), 32'd0);
    tick();
    @(negedge clk); chk("lat_rd_n1", 32'(rob_rd_en), 32'd1);
    chk("lat_cv_n1", 32'(commit_valid), 32'd0);
    @(negedge clk); chk("lat_cv_n2", 32'(commit_valid), 32'd1);
    chk("lat_we", 32'(commit_we), 32'd1);
    chk("lat_areg", 32'(commit_areg), 32'd5);
    chk("lat_value", commit_value, 32'h11);
    complete(1); complete(2);
    wait_commit("drain1", c0);
    wait_commit("drain2", c0);

    // Out-of-order completion retires in order, 2 cycles apart
    do_reset();
    alloc(5'd1, 1'b1, 32'h200, 32'hA0, 1'b0, 32'h0, 0);
    alloc(5'd2, 1'b1, 32'h204, 32'hA1, 1'b0, 32'h0, 1);
    alloc(5'd3, 1'b1, 32'h208, 32'hA2, 1'b0, 32'h0, 2);
    complete(2); complete(1);
    repeat (3) begin @(negedge clk); chk("ooo_hold", 32'(rob_rd_en), 32'd0); end
    complete(0);
    wait_commit("ooo0", c0);
    wait_commit("ooo1", c1);
    wait_commit("ooo2", c2);
    chk("ooo_lat0", 32'(c0), 32'd2);
    chk("ooo_gap1", 32'(c1), 32'd2);
    chk("ooo_gap2", 32'(c2), 32'd2);

    // Full ROB, ignored alloc, wrap and simultaneous alloc/retire
    do_reset();
    for (int i = 0; i < 8; i++)
      alloc(5'(i + 8), 1'b1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'h0, i);
    @(negedge clk);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_tag", 32'(alloc_tag), 32'd0);
    alloc_en = 1'b1;
    tick();
    chk("full_ign_tag", 32'(alloc_tag), 32'd0);
    chk("full_ign_ready", 32'(alloc_ready), 32'd0);
    complete(0);
    wait_commit("full_ret0", c0);
    tick();
    alloc(5'd20, 1'b1, 32'h3F0, 32'h2000, 1'b0, 32'h0, 0);
    chk("refull_ready", 32'(alloc_ready), 32'd0);
    chk("refull_tag", 32'(alloc_tag), 32'd1);
    complete(1);
    wait_commit("full_ret1", c0);
    tick();
    complete(2);
    tick();
    chk("sim_in_wb", 32'(commit_valid), 32'd1);
    alloc(5'd21, 1'b1, 32'h3F4, 32'h2001, 1'b0, 32'h0, 1);
    chk("sim_count_ready", 32'(alloc_ready), 32'd1);
    chk("sim_tag", 32'(alloc_tag), 32'd2);

    // Mispredicted branch: commit, flush, pointer reset, stale CDB ignored
    do_reset();
    alloc(5'd3, 1'b1, 32'h500, 32'h30, 1'b0, 32'h0, 0);
    alloc(5'd4, 1'b1, 32'h504, 32'h40, 1'b1, 32'h400, 1);
    alloc(5'd5, 1'b1, 32'h508, 32'h50, 1'b0, 32'h0, 2);
    alloc(5'd6, 1'b1, 32'h50C, 32'h60, 1'b0, 32'h0, 3);
    complete(1); complete(3); complete(0);
    wait_commit("mp_c0", c0);
    wait_commit("mp_c1", c1);
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_flush_pc", flush_pc, 32'h400);
    chk("mp_ready_in_flush", 32'(alloc_ready), 32'd0);
    tick();
    chk("mp_tag0", 32'(alloc_tag), 32'd0);
    chk("mp_ready", 32'(alloc_ready), 32'd1);
    chk("mp_rd_idle", 32'(rob_rd_en), 32'd0);
    alloc(5'd11, 1'b1, 32'h600, 32'h55, 1'b0, 32'h0, 0);
    complete(3);
    repeat (3) begin @(negedge clk); chk("mp_stale", 32'(rob_rd_en), 32'd0); end
    complete(0);
    wait_commit("mp_after", c0);

    // areg 0 never writes the register file
    do_reset();
    alloc(5'd0, 1'b1, 32'h700, 32'h77, 1'b0, 32'h0, 0);
    complete(0);
    wait_commit("x0", c0);
    chk("x0_we", 32'(commit_we), 32'd0);

    // Reset landing in WB aborts the retirement
    do_reset();
    alloc(5'd9, 1'b1, 32'h800, 32'h99, 1'b0, 32'h0, 0);
    complete(0);
    @(posedge clk); #1;
    rst = 1'b1; exp_q.delete();
    @(negedge clk); chk("rst_wb_no_commit", 32'(commit_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("rst_wb");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
